buffer_ctrl: RTL and testbench



---
 rtl/cnn_pkg.sv | 19 +
 rtl/raster_cnt.sv | 36 +++
 rtl/buffer_ctrl.sv | 120 ++++++++++++
 tb/tb_buffer_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared FSM state type and geometry helpers for the CNN buffer path
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int out_dim(input int ifm, input int k, input int pad, input int stride);
        return (ifm - k + 2 * pad) / stride + 1;
    endfunction

    function automatic int addr_w(input int ifm, input int k, input int pad);
        return $clog2(ifm - k + 2 * pad + 1);
    endfunction

endpackage

// File: rtl/raster_cnt.sv
// rtl/raster_cnt.sv - 2-D raster position counter (ox fast, oy slow), shared by write and read phases
module raster_cnt #(
    parameter int DIM = 5,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ox,
    output logic [W-1:0] oy,
    output logic         wrap,
    output logic         last
);

    localparam logic [W-1:0] MAX = W'(DIM - 1);

    // wrap: this increment ends a row; last: currently on the final row
    assign wrap = inc && (ox == MAX);
    assign last = (oy == MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ox <= '0;
            oy <= '0;
        end else if (inc) begin
            if (ox == MAX) begin
                ox <= '0;
                oy <= (oy == MAX) ? '0 : oy + W'(1);
            end else begin
                ox <= ox + W'(1);
            end
        end
    end

endmodule

// File: rtl/buffer_ctrl.sv
// rtl/buffer_ctrl.sv - strided output buffer address/strobe sequencer; optional err flag under BUF_CTRL_ERR_EN
module buffer_ctrl
    import cnn_pkg::*;
#(
    parameter int IFM_SIZE    = 9,
    parameter int KERNEL_SIZE = 4,
    parameter int STRIDE      = 2,
    parameter int PAD         = 2,
    localparam int OUT_DIM    = out_dim(IFM_SIZE, KERNEL_SIZE, PAD, STRIDE),
    localparam int ADDR       = addr_w(IFM_SIZE, KERNEL_SIZE, PAD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic            rd_ready,
    output logic [ADDR+1:0] addr_x,
    output logic [ADDR+1:0] addr_y,
    output logic            we,
    output logic            re,
    output logic            rd_valid,
    output logic            busy,
`ifdef BUF_CTRL_ERR_EN
    output logic            done,
    output logic            err
`else
    output logic            done
`endif
);

    localparam int AW       = ADDR + 2;
    localparam int MAX_ADDR = (OUT_DIM - 1) * STRIDE + KERNEL_SIZE - 1;
    localparam logic [AW-1:0] STR  = AW'(STRIDE);
    localparam logic [AW-1:0] KOFF = AW'(KERNEL_SIZE - 1);

    generate
        if (MAX_ADDR >= (1 << AW)) begin : g_width_chk
            $error("buffer_ctrl: address width too small for largest read address");
        end
    endgenerate

    state_t        state, state_nxt;
    logic          cnt_inc, cnt_clr, cnt_wrap, cnt_last;
    logic [AW-1:0] ox, oy;

    raster_cnt #(.DIM(OUT_DIM), .W(AW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .ox   (ox),
        .oy   (oy),
        .wrap (cnt_wrap),
        .last (cnt_last)
    );

    // done is registered so it lands the cycle after FLUSH's final rd_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_valid <= re;
            done     <= (state == FLUSH);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (cnt_wrap && cnt_last) state_nxt = READ;
            READ:    if (cnt_wrap && cnt_last) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = (state == IDLE) && start;
        addr_x   = '0;
        addr_y   = '0;
        busy     = (state != IDLE);
        case (state)
            WRITE: begin
                wr_ready = 1'b1;
                we       = wr_valid;
                cnt_inc  = wr_valid;
                addr_x   = ox * STR;
                addr_y   = oy * STR + AW'(1);
            end
            READ: begin
                re      = rd_ready;
                cnt_inc = rd_ready;
                addr_x  = ox * STR + KOFF;
                addr_y  = oy * STR;
            end
            default: ;
        endcase
    end

`ifdef BUF_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((start && busy) || (wr_valid && !wr_ready)) begin
            err <= 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_buffer_ctrl.sv
// tb/tb_buffer_ctrl.sv - self-checking bench for buffer_ctrl against a raster-index reference model
module tb_buffer_ctrl;

    localparam int IFM = 9;
    localparam int K   = 4;
    localparam int S   = 2;
    localparam int P   = 2;
    localparam int OD  = (IFM - K + 2 * P) / S + 1;
    localparam int AWB = $clog2(IFM - K + 2 * P + 1) + 2;
    localparam int NPOS = OD * OD;

    logic           clk = 1'b0;
    logic           rst, start, wr_valid, rd_ready;
    logic           wr_ready, we, re, rd_valid, busy, done;
    logic [AWB-1:0] addr_x, addr_y;
`ifdef BUF_CTRL_ERR_EN
    logic           err;
`endif

    buffer_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_ready (rd_ready),
        .addr_x   (addr_x),
        .addr_y   (addr_y),
        .we       (we),
        .re       (re),
        .rd_valid (rd_valid),
        .busy     (busy),
`ifdef BUF_CTRL_ERR_EN
        .done     (done),
        .err      (err)
`else
        .done     (done)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 write, 2 read, 3 flush; wi/ri are raster indices
    int mphase = 0;
    int wi = 0;
    int ri = 0;
    bit prev_re = 1'b0;
    bit prev_flush = 1'b0;
    bit m_err = 1'b0;

    int we_cnt, re_cnt, done_cnt, wr_cyc;
    logic [2*AWB-1:0] wq[$];
    logic [2*AWB-1:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit st, input bit wv, input bit rr, input bit r);
        int ex, ey;
        bit ewe, ere;
        @(negedge clk);
        start = st; wr_valid = wv; rd_ready = rr; rst = r;
        #1;
        ex = 0; ey = 0;
        ewe = (mphase == 1) && wv;
        ere = (mphase == 2) && rr;
        if (mphase == 1) begin
            ex = (wi % OD) * S;
            ey = (wi / OD) * S + 1;
        end else if (mphase == 2) begin
            ex = (ri % OD) * S + K - 1;
            ey = (ri / OD) * S;
        end
        chk("busy", 32'(busy), 32'(mphase != 0));
        chk("wr_ready", 32'(wr_ready), 32'(mphase == 1));
        chk("we", 32'(we), 32'(ewe));
        chk("re", 32'(re), 32'(ere));
        chk("addr_x", 32'(addr_x), 32'(ex));
        chk("addr_y", 32'(addr_y), 32'(ey));
        chk("rd_valid", 32'(rd_valid), 32'(prev_re));
        chk("done", 32'(done), 32'(prev_flush));
`ifdef BUF_CTRL_ERR_EN
        chk("err", 32'(err), 32'(m_err));
`endif
        if (we === 1'b1) begin we_cnt++; wq.push_back({addr_x, addr_y}); end
        if (re === 1'b1) begin re_cnt++; rq.push_back({addr_x, addr_y}); end
        if (done === 1'b1) done_cnt++;
        if (wr_ready === 1'b1) wr_cyc++;
        @(posedge clk);
        if (r) begin
            mphase = 0; wi = 0; ri = 0;
            prev_re = 1'b0; prev_flush = 1'b0; m_err = 1'b0;
        end else begin
            if ((st && mphase != 0) || (wv && mphase != 1)) m_err = 1'b1;
            prev_re = ere;
            prev_flush = (mphase == 3);
            case (mphase)
                0: if (st) begin mphase = 1; wi = 0; end
                1: if (wv) begin
                       wi++;
                       if (wi == NPOS) begin mphase = 2; ri = 0; end
                   end
                2: if (rr) begin
                       ri++;
                       if (ri == NPOS) mphase = 3;
                   end
                default: mphase = 0;
            endcase
        end
    endtask

    task automatic clear_stats();
        we_cnt = 0; re_cnt = 0; done_cnt = 0; wr_cyc = 0;
        wq.delete(); rq.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);

        // reset state
        step(0, 0, 0, 0);

        // frame A: back-to-back writes, reads with rd_ready high
        clear_stats();
        step(1, 0, 0, 0);
        for (int i = 0; i < NPOS; i++) step(0, 1, 0, 0);
        chk("A_we_count", 32'(we_cnt), 32'(25));
        chk("A_wr_first", 32'(wq[0]), 32'({6'd0, 6'd1}));
        chk("A_wr_sixth", 32'(wq[5]), 32'({6'd0, 6'd3}));
        chk("A_wr_last", 32'(wq[24]), 32'({6'd8, 6'd9}));
        n = 0;
        while (mphase != 0 && n < 40) begin step(0, 0, 1, 0); n++; end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("A_re_count", 32'(re_cnt), 32'(25));
        chk("A_rd_first", 32'(rq[0]), 32'({6'd3, 6'd0}));
        chk("A_rd_last", 32'(rq[24]), 32'({6'd11, 6'd8}));
        chk("A_done_count", 32'(done_cnt), 32'(1));

        // frame B: toggling wr_valid, then a 3-cycle rd_ready stall
        clear_stats();
        step(1, 0, 0, 0);
        n = 0;
        while (mphase == 1 && n < 100) begin step(0, n[0], 0, 0); n++; end
        chk("B_write_cycles", 32'(wr_cyc), 32'(50));
        chk("B_we_count", 32'(we_cnt), 32'(25));
        n = 0;
        while (mphase != 0 && n < 60) begin
            step(0, 0, !(n >= 10 && n < 13), 0);
            n++;
        end
        step(0, 0, 0, 0);
        chk("B_re_count", 32'(re_cnt), 32'(25));
        chk("B_rd_resume", 32'(rq[10]), 32'({6'd3, 6'd4}));
        chk("B_done_count", 32'(done_cnt), 32'(1));

        // frame C: reset after 10 writes, then restart
        clear_stats();
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        wq.delete();
        for (int i = 0; i < NPOS; i++) step(0, 1, 0, 0);
        chk("C_restart_first", 32'(wq[0]), 32'({6'd0, 6'd1}));
        n = 0;
        while (mphase != 0 && n < 40) begin step(0, 0, 1, 0); n++; end
        step(0, 0, 0, 0);
        chk("C_done_count", 32'(done_cnt), 32'(1));

        // frame D: start pulsed mid-write must not disturb the sequence
        clear_stats();
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        n = 0;
        while (mphase == 1 && n < 40) begin step(0, 1, 0, 0); n++; end
        chk("D_we_count", 32'(we_cnt), 32'(25));
        chk("D_wr_eighth", 32'(wq[7]), 32'({6'd4, 6'd3}));
`ifdef BUF_CTRL_ERR_EN
        chk("D_err_set", 32'(err), 32'(1));
`endif
        n = 0;
        while (mphase != 0 && n < 40) begin step(0, 0, 1, 0); n++; end
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // randomized frames: random valid/ready, stray starts and stray wr_valid
        for (int f = 0; f < 4; f++) begin
            clear_stats();
            step(1, 0, 0, 0);
            n = 0;
            while (mphase != 0 && n < 600) begin
                step(($urandom % 16) == 0, $urandom % 2, ($urandom % 4) != 0, 0);
                n++;
            end
            step(0, 0, 0, 0);
            chk("R_we_count", 32'(we_cnt), 32'(NPOS));
            chk("R_re_count", 32'(re_cnt), 32'(NPOS));
            chk("R_done_count", 32'(done_cnt), 32'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
